// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time to
// instruction memory and hands instructions to decode through a 1-entry skid.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_WAIT  = 2'd2,
        ST_KILL  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] req_pc_r;
    logic [31:0] skid_instr_r;
    logic [31:0] skid_pc_r;
    logic        skid_v_r;
    logic [31:0] instr_r;
    logic [31:0] pc_out_r;
    logic        valid_r;
    logic        req_s;
    logic        rsp_keep_s;

    assign imem_req_o  = req_s;
    assign imem_addr_o = pc_r;
    assign instr_o     = instr_r;
    assign pc_o        = pc_out_r;
    assign valid_o     = valid_r;

    // A response is only kept while waiting; in KILL/IDLE/READY it is dropped.
    assign rsp_keep_s = (state_r == ST_WAIT) && imem_rvalid_i;

    // Request decision: never while redirecting, never if the skid would be left full.
    always_comb begin
        req_s = 1'b0;
        if (redirect_i) begin
            req_s = 1'b0;
        end else if (state_r == ST_READY) begin
            req_s = !skid_v_r;
        end else if (state_r == ST_WAIT) begin
            req_s = imem_rvalid_i && !(stall_i && valid_r);
        end else begin
            req_s = 1'b0;
        end
    end

    // Next-state logic for the outstanding-request tracker.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                state_s = ST_READY;
            end
            ST_READY: begin
                if (req_s) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_READY;
                end
            end
            ST_WAIT: begin
                if (redirect_i) begin
                    state_s = imem_rvalid_i ? ST_READY : ST_KILL;
                end else if (req_s) begin
                    state_s = ST_WAIT;
                end else if (imem_rvalid_i) begin
                    state_s = ST_READY;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_KILL: begin
                if (imem_rvalid_i) begin
                    state_s = ST_READY;
                end else begin
                    state_s = ST_KILL;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Next fetch PC; the low two bits of a redirect target are forced to zero.
    always_comb begin
        pc_s = pc_r;
        if (redirect_i) begin
            pc_s = redirect_pc_i & 32'hFFFF_FFFC;
        end else if (req_s) begin
            pc_s = pc_r + 32'd4;
        end else begin
            pc_s = pc_r;
        end
    end

    // State, fetch PC and PC of the request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            pc_r     <= RESET_PC;
            req_pc_r <= 32'd0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            if (req_s) begin
                req_pc_r <= pc_r;
            end
        end
    end

    // Decode-facing output register and skid buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_r      <= NOP_INSTR;
            pc_out_r     <= 32'd0;
            valid_r      <= 1'b0;
            skid_instr_r <= 32'd0;
            skid_pc_r    <= 32'd0;
            skid_v_r     <= 1'b0;
        end else if (redirect_i) begin
            instr_r  <= NOP_INSTR;
            valid_r  <= 1'b0;
            skid_v_r <= 1'b0;
        end else if (rsp_keep_s) begin
            if (!stall_i || !valid_r) begin
                instr_r  <= imem_rdata_i;
                pc_out_r <= req_pc_r;
                valid_r  <= 1'b1;
            end else begin
                skid_instr_r <= imem_rdata_i;
                skid_pc_r    <= req_pc_r;
                skid_v_r     <= 1'b1;
            end
        end else if (!stall_i) begin
            if (skid_v_r) begin
                instr_r  <= skid_instr_r;
                pc_out_r <= skid_pc_r;
                valid_r  <= 1'b1;
                skid_v_r <= 1'b0;
            end else begin
                instr_r <= NOP_INSTR;
                valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a queue-based model of the decode-facing
// instruction stream plus a variable-latency memory, compared every cycle.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    // Model: instructions delivered but not yet consumed by decode (front is shown).
    ent_t        q[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_disp_pc;
    logic [31:0] m_out_pc;
    bit          m_outst;
    bit          m_discard;
    bit          m_started;

    // Memory: at most one pending response, delivered lat cycles after the request.
    bit          mem_pend;
    logic [31:0] mem_addr;
    int          mem_due;
    int          lat;
    int          cyc_n;

    int n_vec;
    int n_miss;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_fetch_pc = 32'h0000_0000;
        m_disp_pc  = 32'h0000_0000;
        m_out_pc   = 32'h0000_0000;
        m_outst    = 1'b0;
        m_discard  = 1'b0;
        m_started  = 1'b0;
    endtask

    task automatic cyc(input logic rst, input logic st, input logic rd, input logic [31:0] rpc);
        logic rv;
        logic exp_req;
        bit   accepted;
        @(negedge clk);
        cyc_n++;
        rv            = mem_pend && (cyc_n == mem_due);
        rst_n         = rst;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? (mem_addr | 32'h0000_0013) : 32'hDEAD_BEEF;
        if (!rst) model_reset();
        if (!rst || !m_started || rd) exp_req = 1'b0;
        else if (!m_outst)            exp_req = (q.size() < 2);
        else if (rv && !m_discard)    exp_req = !(st && q.size() >= 1);
        else                          exp_req = 1'b0;
        #1;
        chk("imem_req",  32'(imem_req_o), 32'(exp_req));
        chk("imem_addr", imem_addr_o, m_fetch_pc);
        chk("valid",     32'(valid_o), 32'(q.size() > 0));
        chk("instr",     instr_o, (q.size() > 0) ? q[0].instr : NOP);
        chk("pc",        pc_o, m_disp_pc);
        if (rv) chk("skid_full_with_rvalid", 32'(dut.skid_v_r), 32'd0);
        if (rst) begin
            accepted = m_outst && rv && !m_discard;
            if (rd) begin
                q.delete();
                m_fetch_pc = rpc & 32'hFFFF_FFFC;
                if (m_outst) begin
                    if (rv) begin
                        m_outst   = 1'b0;
                        m_discard = 1'b0;
                    end else begin
                        m_discard = 1'b1;
                    end
                end
            end else begin
                if (m_outst && rv && m_discard) begin
                    m_outst   = 1'b0;
                    m_discard = 1'b0;
                end
                if (!st && q.size() > 0) void'(q.pop_front());
                if (accepted) begin
                    q.push_back({imem_rdata_i, m_out_pc});
                    m_outst = 1'b0;
                end
                if (exp_req) begin
                    m_out_pc   = m_fetch_pc;
                    m_fetch_pc = m_fetch_pc + 32'd4;
                    m_outst    = 1'b1;
                end
            end
            if (q.size() > 0) m_disp_pc = q[0].pc;
            m_started = 1'b1;
        end
        if (rv) mem_pend = 1'b0;
        if (imem_req_o) begin
            chk("one_outstanding", 32'(mem_pend), 32'd0);
            mem_pend = 1'b1;
            mem_addr = imem_addr_o;
            mem_due  = cyc_n + lat;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        n_vec = 0; n_miss = 0; cyc_n = 0;
        mem_pend = 1'b0; mem_addr = 32'd0; mem_due = 0; lat = 1;
        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
        imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;
        model_reset();

        // Reset state and start-up with a 1-cycle memory
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk("lit_rst_instr", instr_o, 32'h0000_0013);
        chk("lit_rst_valid", 32'(valid_o), 32'd0);
        run(1);
        chk("lit_idle_noreq", 32'(imem_req_o), 32'd0);
        run(1);
        chk("lit_c1_req", 32'(imem_req_o), 32'd1);
        chk("lit_c1_addr", imem_addr_o, 32'h0000_0000);
        run(1);
        chk("lit_c2_valid", 32'(valid_o), 32'd0);
        chk("lit_c2_addr", imem_addr_o, 32'h0000_0004);
        run(1);
        chk("lit_c3_valid", 32'(valid_o), 32'd1);
        chk("lit_c3_pc", pc_o, 32'h0000_0000);
        chk("lit_c3_instr", instr_o, 32'h0000_0013);
        run(3);
        chk("lit_c6_pc", pc_o, 32'h0000_000C);

        // Stall three cycles with 0x10 on the output
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'd0);
            chk("lit_stall_pc", pc_o, 32'h0000_0010);
            if (i > 0) chk("lit_stall_noreq", 32'(imem_req_o), 32'd0);
        end
        run(1);
        chk("lit_release_hold", pc_o, 32'h0000_0010);
        run(1);
        chk("lit_skid_pc", pc_o, 32'h0000_0014);
        chk("lit_skid_instr", instr_o, 32'h0000_0017);
        chk("lit_refill_addr", imem_addr_o, 32'h0000_0018);
        run(2);
        chk("lit_after_skid_pc", pc_o, 32'h0000_0018);
        run(3);

        // 3-cycle memory from reset
        lat = 3;
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        run(6);
        chk("lit_l3_v0", 32'(valid_o), 32'd1);
        chk("lit_l3_pc0", pc_o, 32'h0000_0000);
        run(1);
        chk("lit_l3_bubble", 32'(valid_o), 32'd0);
        run(2);
        chk("lit_l3_pc4", pc_o, 32'h0000_0004);
        run(3);
        chk("lit_l3_pc8", pc_o, 32'h0000_0008);
        run(14);
        chk("lit_req20", imem_addr_o, 32'h0000_0020);
        chk("lit_req20_v", 32'(imem_req_o), 32'd1);

        // Redirect while the request for 0x20 is in flight
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_0103);
        run(1);
        chk("lit_redir_valid", 32'(valid_o), 32'd0);
        chk("lit_redir_instr", instr_o, 32'h0000_0013);
        run(2);
        chk("lit_redir_req", 32'(imem_req_o), 32'd1);
        chk("lit_redir_addr", imem_addr_o, 32'h0000_0100);
        run(4);
        chk("lit_redir_pc", pc_o, 32'h0000_0100);
        chk("lit_redir_v", 32'(valid_o), 32'd1);

        // Redirect together with stall and a full skid
        lat = 1;
        run(8);
        cyc(1'b1, 1'b1, 1'b0, 32'd0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        run(1);
        chk("lit_flush_valid", 32'(valid_o), 32'd0);
        chk("lit_flush_addr", imem_addr_o, 32'h0000_0200);
        run(2);
        chk("lit_flush_pc", pc_o, 32'h0000_0200);
        chk("lit_flush_instr", instr_o, 32'h0000_0213);

        // Redirect mid-stream near the top of memory, then wrap
        run(4);
        cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFA);
        run(3);
        chk("lit_wrap_req", 32'(imem_req_o), 32'd1);
        chk("lit_wrap_addr", imem_addr_o, 32'h0000_0000);
        run(2);
        chk("lit_wrap_pc", pc_o, 32'h0000_0000);
        run(3);

        // Reset in the middle of a 3-cycle request
        lat = 3;
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        run(2);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk("lit_midrst_valid", 32'(valid_o), 32'd0);
        chk("lit_midrst_instr", instr_o, 32'h0000_0013);
        run(2);
        chk("lit_restart_addr", imem_addr_o, 32'h0000_0000);
        chk("lit_restart_req", 32'(imem_req_o), 32'd1);
        run(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
